// File: rtl/instr_fetch_stage.sv
// Fetch stage + IF/ID register: owns the PC, issues imem reads, slices opcode/funct3/funct7 for decode.
// Latency: grant in cycle N, rvalid in cycle M>N -> valid_out from M+1; 0-wait imem gives 1 instr / 2 cycles.
// Backpressure: stall_in holds IF/ID; a response landing under stall parks in a 1-entry skid, fetch pauses while it is full.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   imem_req_out/addr_out      read request (one outstanding), address = PC of the request
//   imem_gnt_in                request accepted when req && gnt
//   imem_rvalid_in/rdata_in    in-order response, at least one cycle after grant
//   stall_in                   hold IF/ID contents
//   redirect_in/redirect_pc_in taken branch from EX: flush IF/ID and skid, restart at target
//   valid_out/pc_out/instr_out IF/ID register; instr_out is NOP_INSTR when empty
//   opcode_out/funct3_out/funct7_out  fields of instr_out for the control unit
// Optional: define IFETCH_PERF_EN to add perf_fetched_out / perf_stall_out counters.
module instr_fetch_stage #(
  parameter int unsigned       XLEN      = 64,
  parameter logic [XLEN-1:0]   RESET_PC  = {XLEN{1'b0}},
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_out,
  output logic [XLEN-1:0] imem_addr_out,
  input  logic            imem_gnt_in,
  input  logic            imem_rvalid_in,
  input  logic [31:0]     imem_rdata_in,
  input  logic            stall_in,
  input  logic            redirect_in,
  input  logic [XLEN-1:0] redirect_pc_in,
  output logic            valid_out,
  output logic [XLEN-1:0] pc_out,
  output logic [31:0]     instr_out,
  output logic [6:0]      opcode_out,
  output logic [2:0]      funct3_out,
  output logic [6:0]      funct7_out
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched_out,
  output logic [31:0]     perf_stall_out
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,   // may issue a request
    WAIT  = 2'd1,   // awaiting a response to keep
    DROP  = 2'd2    // awaiting a response to discard (redirected while in flight)
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'd4};
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            skid_full_q, skid_full_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;

  logic            handshake;
  logic            rsp_take;

  // Fetch is blocked while the skid holds a word, so a response can never
  // arrive while the skid is full.
  assign imem_req_out  = !reset && (state_q == FETCH) && !skid_full_q && !redirect_in;
  assign imem_addr_out = pc_q;
  assign handshake     = imem_req_out && imem_gnt_in;
  // Responses only count in WAIT; in FETCH they are stale (e.g. across reset).
  assign rsp_take      = (state_q == WAIT) && imem_rvalid_in;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    skid_full_d  = skid_full_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    valid_d      = valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;

    case (state_q)
      FETCH: begin
        if (handshake) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_STEP;
          state_d  = WAIT;
        end
      end
      WAIT:    if (imem_rvalid_in) state_d = FETCH;
      DROP:    if (imem_rvalid_in) state_d = FETCH;
      default: state_d = FETCH;
    endcase

    if (!stall_in) begin
      // IF/ID advances: older skid word first, then a fresh response, else bubble.
      if (skid_full_q) begin
        valid_d      = 1'b1;
        ifid_pc_d    = skid_pc_q;
        ifid_instr_d = skid_instr_q;
        skid_full_d  = 1'b0;
      end else if (rsp_take) begin
        valid_d      = 1'b1;
        ifid_pc_d    = req_pc_q;
        ifid_instr_d = imem_rdata_in;
      end else begin
        valid_d      = 1'b0;
        ifid_instr_d = NOP_INSTR;
      end
    end else if (rsp_take) begin
      // Stalled: an empty IF/ID may still fill; a live one is held and the word parks.
      if (!valid_q) begin
        valid_d      = 1'b1;
        ifid_pc_d    = req_pc_q;
        ifid_instr_d = imem_rdata_in;
      end else begin
        skid_full_d  = 1'b1;
        skid_pc_d    = req_pc_q;
        skid_instr_d = imem_rdata_in;
      end
    end

    // Redirect overrides everything above.
    if (redirect_in) begin
      valid_d      = 1'b0;
      ifid_instr_d = NOP_INSTR;
      skid_full_d  = 1'b0;
      pc_d         = redirect_pc_in & ALIGN_MASK;
      // An outstanding request must have its response swallowed, unless it lands now.
      if (state_q != FETCH) state_d = imem_rvalid_in ? FETCH : DROP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      req_pc_q     <= {XLEN{1'b0}};
      skid_full_q  <= 1'b0;
      skid_pc_q    <= {XLEN{1'b0}};
      skid_instr_q <= NOP_INSTR;
      valid_q      <= 1'b0;
      ifid_pc_q    <= {XLEN{1'b0}};
      ifid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      skid_full_q  <= skid_full_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      valid_q      <= valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

  assign valid_out  = valid_q;
  assign pc_out     = ifid_pc_q;
  assign instr_out  = ifid_instr_q;
  assign opcode_out = ifid_instr_q[6:0];
  assign funct3_out = ifid_instr_q[14:12];
  assign funct7_out = ifid_instr_q[31:25];

`ifdef IFETCH_PERF_EN
  logic        ifid_write;
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  // A word is written to IF/ID from the skid or straight from imem.
  assign ifid_write = !redirect_in &&
                      ((!stall_in && (skid_full_q || rsp_take)) ||
                       (stall_in && rsp_take && !valid_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      if (ifid_write)          perf_fetched_q <= perf_fetched_q + 32'd1;
      if (valid_q && stall_in) perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched_out = perf_fetched_q;
  assign perf_stall_out   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
`timescale 1ns/1ps
module tb_instr_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        imem_req_out, imem_gnt_in, imem_rvalid_in;
  logic [63:0] imem_addr_out;
  logic [31:0] imem_rdata_in;
  logic        stall_in, redirect_in;
  logic [63:0] redirect_pc_in;
  logic        valid_out;
  logic [63:0] pc_out;
  logic [31:0] instr_out;
  logic [6:0]  opcode_out, funct7_out;
  logic [2:0]  funct3_out;

  // second instance exercising PC wrap from the top of the address space
  logic        w_req, w_gnt, w_rvalid, w_stall, w_valid;
  logic [63:0] w_addr, w_pc;
  logic [31:0] w_rdata, w_instr;
  logic [6:0]  w_opcode, w_funct7;
  logic [2:0]  w_funct3;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif

  instr_fetch_stage u_dut (
    .clk(clk), .reset(reset),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_gnt_in(imem_gnt_in), .imem_rvalid_in(imem_rvalid_in), .imem_rdata_in(imem_rdata_in),
    .stall_in(stall_in), .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in),
    .valid_out(valid_out), .pc_out(pc_out), .instr_out(instr_out),
    .opcode_out(opcode_out), .funct3_out(funct3_out), .funct7_out(funct7_out)
`ifdef IFETCH_PERF_EN
    , .perf_fetched_out(perf_fetched), .perf_stall_out(perf_stall)
`endif
  );

  instr_fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req_out(w_req), .imem_addr_out(w_addr),
    .imem_gnt_in(w_gnt), .imem_rvalid_in(w_rvalid), .imem_rdata_in(w_rdata),
    .stall_in(w_stall), .redirect_in(1'b0), .redirect_pc_in(64'h0),
    .valid_out(w_valid), .pc_out(w_pc), .instr_out(w_instr),
    .opcode_out(w_opcode), .funct3_out(w_funct3), .funct7_out(w_funct7)
`ifdef IFETCH_PERF_EN
    , .perf_fetched_out(w_perf_fetched), .perf_stall_out(w_perf_stall)
`endif
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] w_addrs[$];
  int          checks = 0;
  int          errors = 0;
  int          consumed = 0;

  // imem model state
  logic        resp_en = 1'b0;
  logic        inflight = 1'b0;
  logic [63:0] inflight_addr = 64'h0;
  logic        w_pending = 1'b0;
  logic [63:0] w_pend_addr = 64'h0;

  // values observed during the cycle just completed by tick()
  logic        s_req;
  logic [63:0] s_addr;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h0000_3083;
      64'h4:   return 32'h0011_3423;
      64'h8:   return 32'h4020_8033;
      default: return {a[19:0], 12'h0B3};
    endcase
  endfunction

  // One clock cycle: present imem response, sample, score IF/ID consumption, advance.
  task automatic tick();
    exp_t e;
    logic hs, w_hs;
    if (resp_en && inflight) begin
      imem_rvalid_in = 1'b1;
      imem_rdata_in  = word_at(inflight_addr);
    end else begin
      imem_rvalid_in = 1'b0;
      imem_rdata_in  = 32'hDEAD_BEEF;
    end
    w_rvalid = w_pending;
    w_rdata  = word_at(w_pend_addr);
    #1;
    s_req  = imem_req_out;
    s_addr = imem_addr_out;
    hs     = imem_req_out && imem_gnt_in;
    if (redirect_in) begin
      sb.delete();
    end else if (valid_out && !stall_in) begin
      checks++;
      consumed++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: IF/ID pc=%h instr=%h but no instruction expected", pc_out, instr_out);
      end else begin
        e = sb.pop_front();
        if (pc_out !== e.pc || instr_out !== e.instr) begin
          errors++;
          $display("FAIL sb_order: got pc=%h instr=%h, expected pc=%h instr=%h", pc_out, instr_out, e.pc, e.instr);
        end
      end
    end
    if (hs) begin
      e.pc    = imem_addr_out;
      e.instr = word_at(imem_addr_out);
      sb.push_back(e);
    end
    w_hs = w_req && w_gnt;
    if (w_hs) w_addrs.push_back(w_addr);
    @(posedge clk);
    if (imem_rvalid_in) inflight = 1'b0;
    if (hs) begin
      inflight      = 1'b1;
      inflight_addr = s_addr;
    end
    w_pending = w_hs;
    if (w_hs) w_pend_addr = w_addr;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_gnt_in = 1'b0; stall_in = 1'b0; redirect_in = 1'b0;
    redirect_pc_in = 64'h0; w_gnt = 1'b0; w_stall = 1'b0; resp_en = 1'b0;
    tick();
    tick();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", s_req); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    checks++; if (instr_out !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", instr_out, NOP); end
    checks++; if (pc_out !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", pc_out); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    imem_gnt_in = 1'b1; resp_en = 1'b1;
    tick();
    checks++; if ({s_req, s_addr} !== {1'b1, 64'h0}) begin errors++; $display("FAIL basic_req0: got req=%b addr=%h expected req=1 addr=0", s_req, s_addr); end
    tick();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL basic_wait_noreq: got %b expected 0", s_req); end
    checks++; if ({valid_out, pc_out, opcode_out} !== {1'b1, 64'h0, 7'h03}) begin errors++; $display("FAIL basic_ld: got v=%b pc=%h op=%h expected v=1 pc=0 op=03", valid_out, pc_out, opcode_out); end
    tick();
    checks++; if ({s_req, s_addr} !== {1'b1, 64'h4}) begin errors++; $display("FAIL basic_req1: got req=%b addr=%h expected req=1 addr=4", s_req, s_addr); end
    checks++; if ({valid_out, instr_out} !== {1'b0, NOP}) begin errors++; $display("FAIL basic_bubble: got v=%b instr=%h expected v=0 instr=%h", valid_out, instr_out, NOP); end
    tick();
    checks++; if ({valid_out, pc_out, opcode_out} !== {1'b1, 64'h4, 7'h23}) begin errors++; $display("FAIL basic_sd: got v=%b pc=%h op=%h expected v=1 pc=4 op=23", valid_out, pc_out, opcode_out); end
  endtask

  task automatic test_decode();
    tick();
    checks++; if ({s_req, s_addr} !== {1'b1, 64'h8}) begin errors++; $display("FAIL decode_req: got req=%b addr=%h expected req=1 addr=8", s_req, s_addr); end
    tick();
    checks++; if ({valid_out, pc_out} !== {1'b1, 64'h8}) begin errors++; $display("FAIL decode_pc: got v=%b pc=%h expected v=1 pc=8", valid_out, pc_out); end
    checks++; if ({opcode_out, funct3_out, funct7_out} !== {7'h33, 3'h0, 7'h20}) begin errors++; $display("FAIL decode_fields: got op=%h f3=%h f7=%h expected op=33 f3=0 f7=20", opcode_out, funct3_out, funct7_out); end
  endtask

  task automatic test_stall_skid();
    stall_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin
        checks++; if ({s_req, s_addr} !== {1'b1, 64'hC}) begin errors++; $display("FAIL stall_req: got req=%b addr=%h expected req=1 addr=c", s_req, s_addr); end
      end else begin
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL stall_noreq[%0d]: got %b expected 0", i, s_req); end
      end
      checks++;
      if ({valid_out, pc_out, instr_out} !== {1'b1, 64'h8, 32'h4020_8033}) begin
        errors++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=8 instr=40208033", i, valid_out, pc_out, instr_out);
      end
    end
    stall_in = 1'b0;
    tick();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL skid_noreq: got %b expected 0", s_req); end
    checks++; if ({valid_out, pc_out, instr_out} !== {1'b1, 64'hC, word_at(64'hC)}) begin errors++; $display("FAIL skid_load: got v=%b pc=%h instr=%h expected pc=c", valid_out, pc_out, instr_out); end
    tick();
    checks++; if ({s_req, s_addr} !== {1'b1, 64'h10}) begin errors++; $display("FAIL skid_then_req: got req=%b addr=%h expected req=1 addr=10", s_req, s_addr); end
  endtask

  task automatic test_redirect_wait();
    resp_en = 1'b0; redirect_in = 1'b1; redirect_pc_in = 64'h1002;
    tick();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rdw_noreq: got %b expected 0", s_req); end
    checks++; if ({valid_out, instr_out} !== {1'b0, NOP}) begin errors++; $display("FAIL rdw_flush: got v=%b instr=%h expected v=0 nop", valid_out, instr_out); end
    redirect_in = 1'b0; resp_en = 1'b1;
    tick();
    checks++; if ({s_req, valid_out} !== 2'b00) begin errors++; $display("FAIL rdw_drop: got req=%b v=%b expected 0 0", s_req, valid_out); end
    tick();
    checks++; if ({s_req, s_addr} !== {1'b1, 64'h1000}) begin errors++; $display("FAIL rdw_target: got req=%b addr=%h expected req=1 addr=1000", s_req, s_addr); end
  endtask

  task automatic test_redirect_collide();
    tick();
    checks++; if ({valid_out, pc_out} !== {1'b1, 64'h1000}) begin errors++; $display("FAIL rdc_ld: got v=%b pc=%h expected v=1 pc=1000", valid_out, pc_out); end
    stall_in = 1'b1;
    tick();
    checks++; if ({s_req, s_addr} !== {1'b1, 64'h1004}) begin errors++; $display("FAIL rdc_req: got req=%b addr=%h expected req=1 addr=1004", s_req, s_addr); end
    redirect_in = 1'b1; redirect_pc_in = 64'h2000;
    tick();
    checks++; if ({valid_out, instr_out} !== {1'b0, NOP}) begin errors++; $display("FAIL rdc_flush: got v=%b instr=%h expected v=0 nop", valid_out, instr_out); end
    redirect_in = 1'b0; stall_in = 1'b0;
    tick();
    checks++; if ({s_req, s_addr, valid_out} !== {1'b1, 64'h2000, 1'b0}) begin errors++; $display("FAIL rdc_target: got req=%b addr=%h v=%b expected req=1 addr=2000 v=0", s_req, s_addr, valid_out); end
    tick();
    checks++; if ({valid_out, pc_out, instr_out} !== {1'b1, 64'h2000, word_at(64'h2000)}) begin errors++; $display("FAIL rdc_resume: got v=%b pc=%h instr=%h expected pc=2000", valid_out, pc_out, instr_out); end
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = consumed;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (consumed - c0 !== 10) begin errors++; $display("FAIL b2b_rate: got %0d instrs in 20 cycles expected 10", consumed - c0); end
    for (int i = 0; i < 400; i++) begin
      stall_in       = ($urandom_range(0, 3) == 0);
      imem_gnt_in    = ($urandom_range(0, 1) == 1);
      resp_en        = ($urandom_range(0, 2) != 0);
      redirect_in    = ($urandom_range(0, 24) == 0);
      redirect_pc_in = {$urandom, $urandom};
      tick();
    end
    stall_in = 1'b0; redirect_in = 1'b0; imem_gnt_in = 1'b1; resp_en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      w_stall = (i == 2 || i == 3);
      w_gnt   = (w_addrs.size() < 3);
      tick();
    end
    w_gnt = 1'b0; w_stall = 1'b0;
    checks++;
    if (w_addrs.size() !== 3) begin
      errors++; $display("FAIL wrap_count: got %0d requests expected 3", w_addrs.size());
    end else begin
      if (w_addrs[0] !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h expected fffffffffffffffc", w_addrs[0]); end
      checks++; if (w_addrs[1] !== 64'h0) begin errors++; $display("FAIL wrap_addr1: got %h expected 0", w_addrs[1]); end
      checks++; if (w_addrs[2] !== 64'h4) begin errors++; $display("FAIL wrap_addr2: got %h expected 4", w_addrs[2]); end
    end
`ifdef IFETCH_PERF_EN
    checks++; if (w_perf_fetched !== 32'd3) begin errors++; $display("FAIL perf_fetched: got %0d expected 3", w_perf_fetched); end
    checks++; if (w_perf_stall !== 32'd2) begin errors++; $display("FAIL perf_stall: got %0d expected 2", w_perf_stall); end
`endif
  endtask

  task automatic test_reset_midflight();
    imem_gnt_in = 1'b0; resp_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    imem_gnt_in = 1'b1; resp_en = 1'b0;
    tick();
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req: got %b expected 1", s_req); end
    imem_gnt_in = 1'b0; reset = 1'b1;
    tick();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rst_mid_noreq: got %b expected 0", s_req); end
    reset = 1'b0;
    sb.delete();
    resp_en = 1'b1;
    tick();
    tick();
    checks++; if ({valid_out, instr_out} !== {1'b0, NOP}) begin errors++; $display("FAIL rst_mid_ignore: got v=%b instr=%h expected v=0 nop", valid_out, instr_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decode();
    test_stall_skid();
    test_redirect_wait();
    test_redirect_collide();
    test_back_to_back();
    test_wrap();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
